// File: rtl/stove_burner.sv
// stove_burner: plant-side burner model. It turns a 0..9 power setting into a
// slot-based PWM drive, where one period is 10 slots of SLOT_CYCLES clocks.
// It also tracks a modelled residual-heat level and reports a registered "hot" flag.
// Optional feature macro: STOVE_BURNER_HYST_EN adds hysteresis to the hot flag.
// Without the macro, hot follows (heat >= HOT_THRESH) directly.
module stove_burner #(
  parameter int SLOT_CYCLES = 5_000_000,
  parameter int HEAT_W      = 8,
  parameter int HEAT_MAX    = 200,
  parameter int COOL_STEP   = 1,
  parameter int HOT_THRESH  = 10,
  parameter int HYST        = 4
) (
  input  logic              clk,
  input  logic              async_nreset,
  input  logic              enable,
  input  logic [3:0]        power,
  output logic              heater_pwm,
  output logic              hot,
  output logic [HEAT_W-1:0] heat_level,
  output logic              period_tick
);

  localparam int                CNT_W      = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [3:0]        LAST_SLOT  = 4'd9;
  localparam logic [HEAT_W:0]   HEAT_MAX_X = (HEAT_W+1)'(HEAT_MAX);
  localparam logic [HEAT_W-1:0] HEAT_MAX_V = HEAT_W'(HEAT_MAX);
  localparam logic [HEAT_W:0]   COOL_X     = (HEAT_W+1)'(COOL_STEP);
  localparam logic [HEAT_W-1:0] SET_V      = HEAT_W'(HOT_THRESH);
`ifdef STOVE_BURNER_HYST_EN
  localparam logic [HEAT_W-1:0] CLR_V      = HEAT_W'(HOT_THRESH - HYST);
`endif

  logic [CNT_W-1:0]  slot_cnt;
  logic [3:0]        slot_idx;
  logic [3:0]        power_latched;
  logic [3:0]        power_clamped;
  logic              slot_end;
  logic              boundary;
  logic [HEAT_W:0]   heat_x;
  logic [HEAT_W:0]   p_x;
  logic [HEAT_W:0]   heat_sum;
  logic [HEAT_W:0]   deficit;
  logic [HEAT_W-1:0] heat_next;

  assign slot_end      = (slot_cnt == CNT_LAST);
  assign boundary      = slot_end && (slot_idx == LAST_SLOT);
  assign power_clamped = (power > LAST_SLOT) ? LAST_SLOT : power;
  assign heat_x        = {1'b0, heat_level};
  assign p_x           = (HEAT_W+1)'(power_latched);

  // Free-running slot counter and slot index; these run even while the burner is disabled.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      slot_cnt <= '0;
      slot_idx <= '0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      slot_idx <= (slot_idx == LAST_SLOT) ? 4'd0 : slot_idx + 4'd1;
    end else begin
      slot_cnt <= slot_cnt + CNT_W'(1);
    end
  end

  // Power is sampled only at period boundaries, but it is dropped at once when the burner is disabled.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      power_latched <= '0;
    end else if (!enable) begin
      power_latched <= '0;
    end else if (boundary) begin
      power_latched <= power_clamped;
    end
  end

  // Saturating heat step for the ending period, computed one bit wider so it cannot wrap.
  always_comb begin
    heat_sum  = '0;
    deficit   = '0;
    heat_next = heat_level;
    if (p_x >= COOL_X) begin
      heat_sum  = heat_x + (p_x - COOL_X);
      heat_next = (heat_sum > HEAT_MAX_X) ? HEAT_MAX_V : heat_sum[HEAT_W-1:0];
    end else begin
      deficit   = COOL_X - p_x;
      heat_next = (deficit > heat_x) ? '0 : heat_level - deficit[HEAT_W-1:0];
    end
  end

  // Registered outputs: PWM drive, period pulse, heat accumulator and hot flag.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      heater_pwm  <= 1'b0;
      period_tick <= 1'b0;
      heat_level  <= '0;
      hot         <= 1'b0;
    end else begin
      heater_pwm  <= enable && (slot_idx < power_latched);
      period_tick <= boundary;
      if (boundary) begin
        heat_level <= heat_next;
      end
`ifdef STOVE_BURNER_HYST_EN
      if (heat_level >= SET_V) begin
        hot <= 1'b1;
      end else if (heat_level < CLR_V) begin
        hot <= 1'b0;
      end
`else
      hot <= (heat_level >= SET_V);
`endif
    end
  end

endmodule

// File: tb/tb_stove_burner.sv
// tb_stove_burner: self-checking bench for stove_burner.
// It uses a 4-cycle slot, so one PWM period is 40 cycles.
// Every cycle is compared against a cycle-count reference model.
// A table of whole-period records carries hand-derived expectations.
// Hand-written sequences cover the mid-period power change, the enable drop with cooling, and the async reset.
module tb_stove_burner;

  localparam int SLOT   = 4;
  localparam int PER    = 10 * SLOT;
  localparam int HMAX   = 20;
  localparam int COOL   = 1;
  localparam int THRESH = 10;
  localparam int HYSTW  = 4;
  localparam int HW     = 8;

  logic          clk          = 1'b0;
  logic          async_nreset = 1'b1;
  logic          enable       = 1'b0;
  logic [3:0]    power        = 4'd0;
  logic          heater_pwm;
  logic          hot;
  logic [HW-1:0] heat_level;
  logic          period_tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         en;
    logic [3:0] pw;
    int         exp_high;
    int         exp_heat;
    bit         exp_hot;
  } vec_t;

  vec_t tbl[12];

  stove_burner #(
    .SLOT_CYCLES(SLOT),
    .HEAT_W     (HW),
    .HEAT_MAX   (HMAX),
    .COOL_STEP  (COOL),
    .HOT_THRESH (THRESH),
    .HYST       (HYSTW)
  ) dut (
    .clk         (clk),
    .async_nreset(async_nreset),
    .enable      (enable),
    .power       (power),
    .heater_pwm  (heater_pwm),
    .hot         (hot),
    .heat_level  (heat_level),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  // Reference model: the position in the period comes from a cycle count since reset.
  // The model then applies the burner rules with plain integer arithmetic.
  int m_cycle, m_p, m_heat, m_pos, m_slot, m_req;
  bit m_pwm, m_hot, m_tick, m_bnd;

  always @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      m_cycle = 0;
      m_p     = 0;
      m_heat  = 0;
      m_pwm   = 0;
      m_hot   = 0;
      m_tick  = 0;
    end else begin
      m_pos  = m_cycle % PER;
      m_slot = m_pos / SLOT;
      m_bnd  = (m_pos == PER - 1);
      m_tick = m_bnd;
      m_pwm  = enable && (m_slot < m_p);
`ifdef STOVE_BURNER_HYST_EN
      if (m_heat >= THRESH) m_hot = 1;
      else if (m_heat < THRESH - HYSTW) m_hot = 0;
`else
      m_hot = (m_heat >= THRESH);
`endif
      if (m_bnd) begin
        m_heat = m_heat + m_p - COOL;
        if (m_heat > HMAX) m_heat = HMAX;
        if (m_heat < 0) m_heat = 0;
      end
      m_req = (int'(power) > 9) ? 9 : int'(power);
      if (!enable) m_p = 0;
      else if (m_bnd) m_p = m_req;
      m_cycle++;
    end
  end

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("model heater_pwm", int'(heater_pwm), int'(m_pwm));
    checkVal("model hot", int'(hot), int'(m_hot));
    checkVal("model heat_level", int'(heat_level), m_heat);
    checkVal("model period_tick", int'(period_tick), int'(m_tick));
  endtask

  task automatic applyStimulus(input bit en, input logic [3:0] pw);
    enable = en;
    power  = pw;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkOutput();
  endtask

  // Runs 40 cycles starting just before slot 0 and counts PWM-high samples and ticks.
  task automatic runPeriod(output int highs, output int ticks);
    highs = 0;
    ticks = 0;
    for (int c = 0; c < PER; c++) begin
      stepCycle();
      highs += int'(heater_pwm);
      ticks += int'(period_tick);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  highs, ticks, n, fall_heat;
    bit  prev_hot;

    tbl[0]  = '{1'b0, 4'd0,  0,  0,  1'b0};
    tbl[1]  = '{1'b1, 4'd3,  0,  0,  1'b0};
    tbl[2]  = '{1'b1, 4'd3,  12, 2,  1'b0};
    tbl[3]  = '{1'b1, 4'd3,  12, 4,  1'b0};
    tbl[4]  = '{1'b1, 4'd12, 12, 6,  1'b0};
    tbl[5]  = '{1'b1, 4'd12, 36, 14, 1'b0};
    tbl[6]  = '{1'b1, 4'd7,  36, 20, 1'b1};
    tbl[7]  = '{1'b1, 4'd7,  28, 20, 1'b1};
    tbl[8]  = '{1'b0, 4'd7,  0,  19, 1'b1};
    tbl[9]  = '{1'b1, 4'd5,  0,  18, 1'b1};
    tbl[10] = '{1'b1, 4'd0,  20, 20, 1'b1};
    tbl[11] = '{1'b1, 4'd0,  0,  19, 1'b1};

    // Hold reset, check the reset state, then release on a falling edge
    #2 async_nreset = 1'b0;
    repeat (3) stepCycle();
    checkVal("reset heater_pwm", int'(heater_pwm), 0);
    checkVal("reset hot", int'(hot), 0);
    checkVal("reset heat_level", int'(heat_level), 0);
    checkVal("reset period_tick", int'(period_tick), 0);
    async_nreset = 1'b1;

    // Disabled burner: outputs stay low while the tick keeps its 40-cycle rhythm
    applyStimulus(1'b0, 4'd0);
    for (int p = 0; p < 5; p++) begin
      runPeriod(highs, ticks);
      checkVal("idle highs", highs, 0);
      checkVal("idle ticks", ticks, 1);
      checkVal("idle tick end", int'(period_tick), 1);
      checkVal("idle heat", int'(heat_level), 0);
    end

    // Whole-period records
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].en, tbl[i].pw);
      runPeriod(highs, ticks);
      checkVal($sformatf("tbl[%0d] highs", i), highs, tbl[i].exp_high);
      checkVal($sformatf("tbl[%0d] heat", i), int'(heat_level), tbl[i].exp_heat);
      checkVal($sformatf("tbl[%0d] hot", i), int'(hot), int'(tbl[i].exp_hot));
      checkVal($sformatf("tbl[%0d] ticks", i), ticks, 1);
      checkVal($sformatf("tbl[%0d] tick end", i), int'(period_tick), 1);
    end

    // Mid-period power change 3->7: the current period keeps power 3
    applyStimulus(1'b1, 4'd3);
    runPeriod(highs, ticks);
    checkVal("prep highs", highs, 0);
    checkVal("prep heat", int'(heat_level), 18);
    highs = 0;
    for (int c = 0; c < PER; c++) begin
      if (c == PER / 2) applyStimulus(1'b1, 4'd7);
      stepCycle();
      highs += int'(heater_pwm);
    end
    checkVal("midchange highs", highs, 12);
    checkVal("midchange heat", int'(heat_level), 20);
    runPeriod(highs, ticks);
    checkVal("after change highs", highs, 28);
    checkVal("after change heat", int'(heat_level), 20);

    // Enable drop while the PWM is high, then cool down to the floor
    stepCycle();
    stepCycle();
    checkVal("pre-drop pwm", int'(heater_pwm), 1);
    applyStimulus(1'b0, 4'd7);
    stepCycle();
    checkVal("drop pwm", int'(heater_pwm), 0);
    prev_hot  = hot;
    fall_heat = -1;
    for (int c = 0; c < 30 * PER; c++) begin
      stepCycle();
      if (prev_hot && !hot) fall_heat = int'(heat_level);
      prev_hot = hot;
      if (heat_level == '0) break;
    end
    checkVal("cool to zero", int'(heat_level), 0);
`ifdef STOVE_BURNER_HYST_EN
    checkVal("hot fall heat", fall_heat, THRESH - HYSTW - 1);
`else
    checkVal("hot fall heat", fall_heat, THRESH - 1);
`endif
    runPeriod(highs, ticks);
    checkVal("floor heat", int'(heat_level), 0);
    checkVal("floor hot", int'(hot), 0);
    checkVal("floor highs", highs, 0);

    // Build heat to 14 at power 8, then assert reset mid-cycle while the PWM is high
    applyStimulus(1'b1, 4'd8);
    runPeriod(highs, ticks);
    checkVal("build0 heat", int'(heat_level), 0);
    runPeriod(highs, ticks);
    checkVal("build1 highs", highs, 32);
    checkVal("build1 heat", int'(heat_level), 7);
    runPeriod(highs, ticks);
    checkVal("build2 heat", int'(heat_level), 14);
    stepCycle();
    stepCycle();
    checkVal("pre-reset pwm", int'(heater_pwm), 1);
    checkVal("pre-reset hot", int'(hot), 1);
    #2 async_nreset = 1'b0;
    #1;
    checkVal("async heater_pwm", int'(heater_pwm), 0);
    checkVal("async hot", int'(hot), 0);
    checkVal("async heat_level", int'(heat_level), 0);
    checkVal("async period_tick", int'(period_tick), 0);
    stepCycle();
    async_nreset = 1'b1;
    n = 0;
    for (int c = 0; c < 3 * PER; c++) begin
      stepCycle();
      n++;
      if (period_tick) break;
    end
    checkVal("first tick after reset", n, PER);

    // Randomized enable/power traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        applyStimulus($urandom_range(0, 5) != 0, 4'($urandom_range(0, 15)));
      end
      stepCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
